// File: rtl/stage_if.sv
// ============================================================================
//  Module   : stage_if
//  Brief    : Instruction fetch stage with a Wishbone-classic master and a
//             2-entry instruction/PC FIFO feeding the decode stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module stage_if #(
   parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] iwbm_addr_o,
   output logic        iwbm_cyc_o,
   output logic        iwbm_stb_o,
   input  logic [31:0] iwbm_dat_i,
   input  logic        iwbm_ack_i,
   input  logic        iwbm_err_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        trap_i,
   input  logic [31:0] trap_addr_i,
   input  logic        stall_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   output logic        e_inst_addr_misaligned_o,
   output logic        e_inst_access_fault_o
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_KILL  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  count_q, count_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] ent_inst_q [2];
   logic [31:0] ent_pc_q   [2];
   logic        ent_mis_q  [2];
   logic        ent_flt_q  [2];

   logic        redirect;
   logic [31:0] target;
   logic [31:0] base_pc;
   logic        outst;
   logic        done;
   logic        push_bus;
   logic        push_mis;
   logic        push;
   logic        pop;
   logic [1:0]  cnt_base;
   logic        wr_idx;
   logic [31:0] new_inst;
   logic [31:0] new_pc;
   logic        new_mis;
   logic        new_flt;

   // State register. Reset parks in WAIT so the first request rises one edge later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_WAIT;
         pc_q    <= RESET_ADDR;
         addr_q  <= RESET_ADDR;
         count_q <= 2'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_inst_q[i] <= NOP_INST;
            ent_pc_q[i]   <= 32'd0;
            ent_mis_q[i]  <= 1'b0;
            ent_flt_q[i]  <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         if (push) begin
            ent_inst_q[wr_idx] <= new_inst;
            ent_pc_q[wr_idx]   <= new_pc;
            ent_mis_q[wr_idx]  <= new_mis;
            ent_flt_q[wr_idx]  <= new_flt;
         end
      end
   end

   // Next-state: a redirect flushes the FIFO and replaces the fetch PC; any
   // completion seen during a redirect or in KILL is discarded.
   always_comb begin
      redirect = trap_i | branch_taken_i;
      target   = trap_i ? trap_addr_i : branch_target_i;
      base_pc  = redirect ? target : pc_q;
      outst    = (state_q == S_FETCH) || (state_q == S_KILL);
      done     = outst & (iwbm_ack_i | iwbm_err_i);
      push_bus = (state_q == S_FETCH) & done & ~redirect;
      pop      = (count_q != 2'd0) & ~stall_i & ~redirect;
      cnt_base = redirect ? 2'd0 : (count_q - {1'b0, pop} + {1'b0, push_bus});
      state_d  = state_q;
      pc_d     = base_pc;
      addr_d   = addr_q;
      push_mis = 1'b0;
      if (outst && !done) begin
         state_d = redirect ? S_KILL : state_q;
      end else if (push_bus && iwbm_err_i) begin
         state_d = S_HALT;
      end else if ((state_q == S_HALT) && !redirect) begin
         state_d = S_HALT;
      end else if (cnt_base <= 2'd1) begin
         if (base_pc[1:0] != 2'b00) begin
            push_mis = 1'b1;
            state_d  = S_HALT;
         end else begin
            state_d = S_FETCH;
            addr_d  = base_pc;
            pc_d    = base_pc + 32'd4;
         end
      end else begin
         state_d = S_WAIT;
      end

      push    = push_bus | push_mis;
      wr_idx  = redirect ? 1'b0 : wr_q;
      rd_d    = redirect ? 1'b0 : (rd_q ^ pop);
      wr_d    = wr_idx ^ push;
      count_d = cnt_base + {1'b0, push_mis};

      if (push_bus) begin
         new_inst = iwbm_err_i ? NOP_INST : iwbm_dat_i;
         new_pc   = addr_q;
         new_mis  = 1'b0;
         new_flt  = iwbm_err_i;
      end else begin
         new_inst = NOP_INST;
         new_pc   = base_pc;
         new_mis  = 1'b1;
         new_flt  = 1'b0;
      end
   end

   // Outputs
   always_comb begin
      iwbm_cyc_o               = outst;
      iwbm_stb_o               = outst;
      iwbm_addr_o              = addr_q;
      valid_o                  = (count_q != 2'd0);
      instruction_o            = valid_o ? ent_inst_q[rd_q] : NOP_INST;
      pc_o                     = valid_o ? ent_pc_q[rd_q] : 32'd0;
      e_inst_addr_misaligned_o = valid_o & ent_mis_q[rd_q];
      e_inst_access_fault_o    = valid_o & ent_flt_q[rd_q];
   end

endmodule

`default_nettype wire

// File: tb/tb_stage_if.sv
// ============================================================================
//  Module   : tb_stage_if
//  Brief    : Directed self-checking bench for stage_if with a simple slave.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stage_if;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] iwbm_addr_o;
   logic        iwbm_cyc_o;
   logic        iwbm_stb_o;
   logic [31:0] iwbm_dat_i;
   logic        iwbm_ack_i;
   logic        iwbm_err_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        trap_i;
   logic [31:0] trap_addr_i;
   logic        stall_i;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        e_inst_addr_misaligned_o;
   logic        e_inst_access_fault_o;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int          checks   = 0;
   int          failures = 0;
   int          ack_delay;
   int          wcnt;
   logic        err_en;
   logic [31:0] err_addr;

   always #5 clk_i = ~clk_i;

   stage_if dut (
      .clk_i                    (clk_i),
      .rst_i                    (rst_i),
      .iwbm_addr_o              (iwbm_addr_o),
      .iwbm_cyc_o               (iwbm_cyc_o),
      .iwbm_stb_o               (iwbm_stb_o),
      .iwbm_dat_i               (iwbm_dat_i),
      .iwbm_ack_i               (iwbm_ack_i),
      .iwbm_err_i               (iwbm_err_i),
      .branch_taken_i           (branch_taken_i),
      .branch_target_i          (branch_target_i),
      .trap_i                   (trap_i),
      .trap_addr_i              (trap_addr_i),
      .stall_i                  (stall_i),
      .instruction_o            (instruction_o),
      .pc_o                     (pc_o),
      .valid_o                  (valid_o),
      .e_inst_addr_misaligned_o (e_inst_addr_misaligned_o),
      .e_inst_access_fault_o    (e_inst_access_fault_o)
   );

   // Slave: data is the inverted address; ack after ack_delay cycles of strobe.
   assign iwbm_err_i = iwbm_stb_o && err_en && (iwbm_addr_o == err_addr);
   assign iwbm_ack_i = iwbm_stb_o && !iwbm_err_i && (wcnt >= ack_delay);
   assign iwbm_dat_i = ~iwbm_addr_o;

   always @(posedge clk_i) begin
      if (!iwbm_stb_o || iwbm_ack_i || iwbm_err_i) wcnt <= 0;
      else                                        wcnt <= wcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      chk("rst_stb",   {31'd0, iwbm_stb_o}, 32'd0);
      chk("rst_cyc",   {31'd0, iwbm_cyc_o}, 32'd0);
      chk("rst_addr",  iwbm_addr_o, 32'h8000_0000);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_inst",  instruction_o, NOP);
      chk("rst_pc",    pc_o, 32'd0);
      chk("rst_flags", {30'd0, e_inst_addr_misaligned_o, e_inst_access_fault_o}, 32'd0);
      rst_i = 1'b0;
   endtask

   initial begin
      wcnt            = 0;
      ack_delay       = 0;
      err_en          = 1'b0;
      err_addr        = 32'd0;
      branch_taken_i  = 1'b0;
      branch_target_i = 32'd0;
      trap_i          = 1'b0;
      trap_addr_i     = 32'd0;
      stall_i         = 1'b0;

      // Zero-wait streaming
      do_reset();
      tick();
      chk("t1_addr0", iwbm_addr_o, 32'h8000_0000);
      chk("t1_stb0",  {31'd0, iwbm_stb_o}, 32'd1);
      chk("t1_val0",  {31'd0, valid_o}, 32'd0);
      tick();
      chk("t1_addr1", iwbm_addr_o, 32'h8000_0004);
      chk("t1_val1",  {31'd0, valid_o}, 32'd1);
      chk("t1_pc1",   pc_o, 32'h8000_0000);
      chk("t1_inst1", instruction_o, 32'h7FFF_FFFF);
      tick();
      chk("t1_addr2", iwbm_addr_o, 32'h8000_0008);
      chk("t1_pc2",   pc_o, 32'h8000_0004);
      chk("t1_inst2", instruction_o, 32'h7FFF_FFFB);

      // Stall fills the FIFO, then drains in order
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("t2_stb_wait", {31'd0, iwbm_stb_o}, 32'd0);
      chk("t2_head",     pc_o, 32'h8000_0004);
      chk("t2_valid",    {31'd0, valid_o}, 32'd1);
      stall_i = 1'b0;
      tick();
      chk("t2_pc_a",   pc_o, 32'h8000_0008);
      chk("t2_addr_a", iwbm_addr_o, 32'h8000_000C);
      chk("t2_stb_a",  {31'd0, iwbm_stb_o}, 32'd1);
      tick();
      chk("t2_pc_b",   pc_o, 32'h8000_000C);

      // Redirect while a slow request is outstanding
      ack_delay = 3;
      do_reset();
      tick();
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h8000_0100;
      tick();
      branch_taken_i = 1'b0;
      chk("t3_kill_stb",  {31'd0, iwbm_stb_o}, 32'd1);
      chk("t3_kill_addr", iwbm_addr_o, 32'h8000_0000);
      chk("t3_kill_val",  {31'd0, valid_o}, 32'd0);
      tick();
      tick();
      chk("t3_hold_addr", iwbm_addr_o, 32'h8000_0000);
      chk("t3_ack",       {31'd0, iwbm_ack_i}, 32'd1);
      tick();
      chk("t3_new_addr", iwbm_addr_o, 32'h8000_0100);
      chk("t3_new_val",  {31'd0, valid_o}, 32'd0);
      ack_delay = 0;
      tick();
      chk("t3_pc",   pc_o, 32'h8000_0100);
      chk("t3_inst", instruction_o, 32'h7FFF_FEFF);

      // Trap beats branch in the same cycle
      do_reset();
      tick();
      tick();
      trap_i          = 1'b1;
      trap_addr_i     = 32'h8000_0040;
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h8000_0100;
      tick();
      trap_i         = 1'b0;
      branch_taken_i = 1'b0;
      chk("t4_addr", iwbm_addr_o, 32'h8000_0040);
      chk("t4_val",  {31'd0, valid_o}, 32'd0);
      tick();
      chk("t4_pc",   pc_o, 32'h8000_0040);

      // Misaligned branch target
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h8000_0102;
      tick();
      branch_taken_i = 1'b0;
      chk("t5_stb",  {31'd0, iwbm_stb_o}, 32'd0);
      chk("t5_pc",   pc_o, 32'h8000_0102);
      chk("t5_mis",  {31'd0, e_inst_addr_misaligned_o}, 32'd1);
      chk("t5_flt",  {31'd0, e_inst_access_fault_o}, 32'd0);
      chk("t5_inst", instruction_o, NOP);
      tick();
      chk("t5_pop",  {31'd0, valid_o}, 32'd0);
      tick();
      chk("t5_halt", {31'd0, iwbm_stb_o}, 32'd0);
      trap_i      = 1'b1;
      trap_addr_i = 32'h8000_0200;
      tick();
      trap_i = 1'b0;
      chk("t5_resume", iwbm_addr_o, 32'h8000_0200);
      chk("t5_rstb",   {31'd0, iwbm_stb_o}, 32'd1);

      // Bus error, then asynchronous reset mid-cycle
      do_reset();
      tick();
      err_en          = 1'b1;
      err_addr        = 32'h0000_1000;
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h0000_1000;
      tick();
      branch_taken_i = 1'b0;
      chk("t6_addr", iwbm_addr_o, 32'h0000_1000);
      tick();
      chk("t6_stb",   {31'd0, iwbm_stb_o}, 32'd0);
      chk("t6_val",   {31'd0, valid_o}, 32'd1);
      chk("t6_pc",    pc_o, 32'h0000_1000);
      chk("t6_flt",   {31'd0, e_inst_access_fault_o}, 32'd1);
      chk("t6_mis",   {31'd0, e_inst_addr_misaligned_o}, 32'd0);
      chk("t6_inst",  instruction_o, NOP);
      tick();
      tick();
      chk("t6_halt",  {31'd0, iwbm_stb_o}, 32'd0);
      err_en      = 1'b0;
      trap_i      = 1'b1;
      trap_addr_i = 32'h8000_0000;
      tick();
      trap_i = 1'b0;
      chk("t6_live", {31'd0, iwbm_stb_o}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t6_async_stb",  {31'd0, iwbm_stb_o}, 32'd0);
      chk("t6_async_addr", iwbm_addr_o, 32'h8000_0000);
      tick();
      rst_i = 1'b0;

      // PC wrap at the top of the address space
      do_reset();
      tick();
      branch_taken_i  = 1'b1;
      branch_target_i = 32'hFFFF_FFFC;
      tick();
      branch_taken_i = 1'b0;
      chk("wrap_addr0", iwbm_addr_o, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr1", iwbm_addr_o, 32'h0000_0000);
      chk("wrap_pc",    pc_o, 32'hFFFF_FFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
